// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 UART transmitter with a one-byte holding register.
// A byte written while a frame is shifting waits in the holding register and
// follows the current frame with no idle gap. A byte written while the holding
// register is already full is dropped and raises the sticky tx_overrun flag.
// Optional macro UART_TX_PARITY_EN adds an even-parity bit before the stop bit.
module uart_tx_serializer #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 115200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_en,
   input  logic [7:0] tx_data,
   output logic       tx_busy,
   output logic       tx,
   output logic       tx_done,
   output logic       tx_overrun
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [2:0]       bit_reg, bit_next;
   logic [7:0]       shift_reg, shift_next;
   logic [7:0]       hold_reg, hold_next;
   logic             hold_valid_reg, hold_valid_next;
   logic             tx_reg, tx_next;
   logic             done_reg, done_next;
   logic             overrun_reg, overrun_next;
   logic             busy_reg, busy_next;
   logic             bit_end;
   logic             drain;
`ifdef UART_TX_PARITY_EN
   logic             par_reg, par_next;
`endif

   assign tx         = tx_reg;
   assign tx_busy    = busy_reg;
   assign tx_done    = done_reg;
   assign tx_overrun = overrun_reg;
   assign bit_end    = (cnt_reg == CNT_LAST);

   // Next-state logic: frame sequencing, holding-register accept/drain, flags
   always_comb begin
      state_next      = state_reg;
      cnt_next        = bit_end ? '0 : cnt_reg + CNT_W'(1);
      bit_next        = bit_reg;
      shift_next      = shift_reg;
      hold_next       = hold_reg;
      hold_valid_next = hold_valid_reg;
      tx_next         = tx_reg;
      done_next       = 1'b0;
      overrun_next    = overrun_reg;
      drain           = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_next        = par_reg;
`endif

      case (state_reg)
         S_IDLE: begin
            cnt_next = '0;
            tx_next  = 1'b1;
            // A held byte left behind by a strobe on the final stop edge goes out first
            if (hold_valid_reg || tx_en) begin
               drain           = hold_valid_reg;
               shift_next      = hold_valid_reg ? hold_reg : tx_data;
               hold_valid_next = 1'b0;
               state_next      = S_START;
               tx_next         = 1'b0;
`ifdef UART_TX_PARITY_EN
               par_next        = hold_valid_reg ? ^hold_reg : ^tx_data;
`endif
            end
         end
         S_START: begin
            if (bit_end) begin
               state_next = S_DATA;
               bit_next   = 3'd0;
               tx_next    = shift_reg[0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_next = S_PARITY;
                  tx_next    = par_reg;
`else
                  state_next = S_STOP;
                  tx_next    = 1'b1;
`endif
               end else begin
                  bit_next   = bit_reg + 3'd1;
                  shift_next = {1'b0, shift_reg[7:1]};
                  tx_next    = shift_reg[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               state_next = S_STOP;
               tx_next    = 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               done_next = 1'b1;
               if (hold_valid_reg) begin
                  drain           = 1'b1;
                  shift_next      = hold_reg;
                  hold_valid_next = 1'b0;
                  state_next      = S_START;
                  tx_next         = 1'b0;
`ifdef UART_TX_PARITY_EN
                  par_next        = ^hold_reg;
`endif
               end else begin
                  state_next = S_IDLE;
                  tx_next    = 1'b1;
               end
            end
         end
         default: begin
            state_next = S_IDLE;
            tx_next    = 1'b1;
         end
      endcase

      // Holding register: free slot, or the slot being emptied on this edge
      if (tx_en) begin
         if (drain || (state_reg != S_IDLE && !hold_valid_reg)) begin
            hold_next       = tx_data;
            hold_valid_next = 1'b1;
         end else if (hold_valid_reg) begin
            overrun_next = 1'b1;
         end
      end

      busy_next = (state_next != S_IDLE) || hold_valid_next;
   end

   // State register; reset abandons any frame and forces the line idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= S_IDLE;
         cnt_reg        <= '0;
         bit_reg        <= '0;
         shift_reg      <= '0;
         hold_reg       <= '0;
         hold_valid_reg <= 1'b0;
         tx_reg         <= 1'b1;
         done_reg       <= 1'b0;
         overrun_reg    <= 1'b0;
         busy_reg       <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_reg        <= 1'b0;
`endif
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         bit_reg        <= bit_next;
         shift_reg      <= shift_next;
         hold_reg       <= hold_next;
         hold_valid_reg <= hold_valid_next;
         tx_reg         <= tx_next;
         done_reg       <= done_next;
         overrun_reg    <= overrun_next;
         busy_reg       <= busy_next;
`ifdef UART_TX_PARITY_EN
         par_reg        <= par_next;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Testbench for uart_tx_serializer (CLKS_PER_BIT = 10). Honours UART_TX_PARITY_EN.
// A timeline reference model schedules each accepted byte as a frame interval
// and predicts tx/tx_done/tx_busy/tx_overrun every cycle; a line receiver
// decodes tx independently; a constant table checks individual frames.
module tb_uart_tx_serializer;

   localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FL = CPB * NB;
   localparam int MAXF = 1024;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tx_en = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_busy, tx, tx_done, tx_overrun;

   always #5 clk = ~clk;

   uart_tx_serializer #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (
      .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .tx_data(tx_data),
      .tx_busy(tx_busy), .tx(tx), .tx_done(tx_done), .tx_overrun(tx_overrun)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // reference model: frame i accepted at edge m_acc, occupies the line m_st..m_en
   int         m_acc[MAXF];
   int         m_st[MAXF];
   int         m_en[MAXF];
   logic [7:0] m_dat[MAXF];
   int         nf = 0;
   int         base = 0;
   logic       m_ovr = 1'b0;
   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];

   // line receiver state
   logic       rx_active = 1'b0;
   int         rx_k = 0;
   logic [7:0] rx_byte = 8'h00;

   typedef struct {
      logic [7:0]  data;
      logic [10:0] frame;   // bit i = line level in bit slot i
   } vec_t;
   vec_t vecs[6];

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
      end
   endtask

   function automatic logic exp_bit(input logic [7:0] d, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return d[3'(idx - 1)];
`ifdef UART_TX_PARITY_EN
      if (idx == 9) return ^d;
`endif
      return 1'b1;
   endfunction

   task automatic model_add(input int a, input int s, input logic [7:0] d);
      if (nf >= MAXF) begin
         $display("FAIL model_capacity cyc=%0d actual=%0d required<%0d", cyc, nf, MAXF);
         $fatal(1);
      end
      m_acc[nf] = a;
      m_st[nf]  = s;
      m_en[nf]  = s + FL;
      m_dat[nf] = d;
      nf++;
      exp_q.push_back(d);
   endtask

   // Decide the fate of a strobe sampled on edge t
   task automatic model_accept(input int t, input logic [7:0] d);
      bit nonidle = 0;
      bit held = 0;
      bit drain = 0;
      int latest = 0;
      for (int i = base; i < nf; i++) begin
         if (m_st[i] < t && t <= m_en[i]) nonidle = 1;
         if (m_acc[i] < t && t <= m_st[i]) held = 1;
         if (m_acc[i] < t && m_st[i] == t) drain = 1;
         if (m_en[i] > latest) latest = m_en[i];
      end
      if (!nonidle && !held) model_add(t, t, d);
      else if (!held || drain) model_add(t, (latest > t + 1) ? latest : t + 1, d);
      else m_ovr = 1'b1;
   endtask

   task automatic model_expect(input int k, output logic etx, output logic edone,
                               output logic ebusy);
      etx = 1'b1;
      edone = 1'b0;
      ebusy = 1'b0;
      for (int i = base; i < nf; i++) begin
         if (m_st[i] <= k && k < m_en[i]) etx = exp_bit(m_dat[i], (k - m_st[i]) / CPB);
         if (m_en[i] == k) edone = 1'b1;
         if (m_acc[i] <= k && k < m_en[i]) ebusy = 1'b1;
      end
   endtask

   // One clock: model update at the edge, compare #1 later, run the receiver
   task automatic step();
      logic etx, edone, ebusy;
      @(posedge clk);
      cyc++;
      if (tx_en && rst_n) model_accept(cyc, tx_data);
      #1;
      model_expect(cyc, etx, edone, ebusy);
      check("tx", tx, etx);
      check("tx_done", tx_done, edone);
      check("tx_busy", tx_busy, ebusy);
      check("tx_overrun", tx_overrun, m_ovr);
      if (!rst_n) begin
         rx_active = 1'b0;
      end else if (!rx_active) begin
         if (tx == 1'b0) begin
            rx_active = 1'b1;
            rx_k = 0;
         end
      end else begin
         rx_k++;
         if (rx_k % CPB == CPB / 2) begin
            int j;
            j = rx_k / CPB;
            if (j == 0) check("rx_start", tx, 1'b0);
            else if (j <= 8) rx_byte[3'(j - 1)] = tx;
`ifdef UART_TX_PARITY_EN
            else if (j == 9) check("rx_parity", tx, ^rx_byte);
`endif
            if (j == NB - 1) begin
               check("rx_stop", tx, 1'b1);
               rx_q.push_back(rx_byte);
               rx_active = 1'b0;
            end
         end
      end
      while (base < nf && m_en[base] < cyc) base++;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic strobe(input logic [7:0] d);
      tx_data = d;
      tx_en = 1'b1;
      step();
      tx_en = 1'b0;
   endtask

   task automatic flush_queues();
      exp_q.delete();
      rx_q.delete();
   endtask

   task automatic compare_rx(input string name);
      check_int({name, "_count"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
         check_int({name, "_byte"}, int'(rx_q[i]), int'(exp_q[i]));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      base = nf;
      m_ovr = 1'b0;
      rx_active = 1'b0;
      flush_queues();
      idle(3);
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic send_gated(input logic [7:0] d);
      int budget;
      budget = 0;
      while (tx_busy && budget < 3 * FL) begin
         step();
         budget++;
      end
      if (tx_busy) check("gate_timeout", tx_busy, 1'b0);
      strobe(d);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout cyc=%0d actual=running required=finished", cyc);
      $fatal(1);
   end

   initial begin
      logic [7:0] msg[7];
      int t0;
      int k;
      msg = '{8'h3C, 8'h31, 8'h32, 8'h33, 8'h3E, 8'h0D, 8'h0A};
`ifdef UART_TX_PARITY_EN
      vecs[0] = '{8'h3C, 11'h478};
      vecs[1] = '{8'h31, 11'h662};
      vecs[2] = '{8'h00, 11'h400};
      vecs[3] = '{8'hFF, 11'h5FE};
      vecs[4] = '{8'hA5, 11'h54A};
      vecs[5] = '{8'h01, 11'h602};
`else
      vecs[0] = '{8'h3C, 11'h278};
      vecs[1] = '{8'h31, 11'h262};
      vecs[2] = '{8'h00, 11'h200};
      vecs[3] = '{8'hFF, 11'h3FE};
      vecs[4] = '{8'hA5, 11'h34A};
      vecs[5] = '{8'h01, 11'h202};
`endif

      // reset then quiet line
      idle(3);
      rst_n = 1'b1;
      idle(50);
      check("idle_tx", tx, 1'b1);
      check("idle_busy", tx_busy, 1'b0);

      // single frames against constant bit patterns
      flush_queues();
      for (int v = 0; v < 6; v++) begin
         idle(5);
         t0 = cyc + 1;
         strobe(vecs[v].data);
         for (int s = 0; s <= FL + 1; s++) begin
            k = cyc - t0;
            if (k % CPB == CPB / 2) check("vec_bit", tx, vecs[v].frame[k / CPB]);
            check("vec_done", tx_done, k == FL);
            if (k == FL) check("vec_busy_low", tx_busy, 1'b0);
            step();
         end
      end
      compare_rx("vec_rx");

      // back-to-back strobes: no gap, no overrun, two done pulses
      flush_queues();
      idle(5);
      t0 = cyc + 1;
      strobe(8'h3C);
      strobe(8'h31);
      for (int s = 0; s < 2 * FL + 5; s++) begin
         k = cyc - t0;
         check("b2b_done", tx_done, (k == FL) || (k == 2 * FL));
         step();
      end
      check("b2b_overrun", tx_overrun, 1'b0);
      compare_rx("b2b_rx");

      // third consecutive strobe is dropped; overrun sticks until reset
      flush_queues();
      strobe(8'h41);
      strobe(8'h42);
      strobe(8'h43);
      check("ovr_set", tx_overrun, 1'b1);
      idle(2 * FL + 30);
      check("ovr_sticky", tx_overrun, 1'b1);
      check_int("ovr_rx_count", rx_q.size(), 2);
      compare_rx("ovr_rx");
      do_reset();
      check("ovr_cleared", tx_overrun, 1'b0);

      // randomized strobes, singles and bursts
      flush_queues();
      for (int n = 0; n < 3000; n++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 3) strobe(8'($urandom));
         else if (r == 3) begin
            strobe(8'($urandom));
            strobe(8'($urandom));
            strobe(8'($urandom));
         end else step();
      end
      idle(3 * FL);
      compare_rx("rand_rx");
      do_reset();

      // busy-gated message, reset during the third frame, then a clean run
      for (int i = 0; i < 3; i++) send_gated(msg[i]);
      idle(FL / 2);
      check_int("rst_rx_count", rx_q.size(), 2);
      if (rx_q.size() == 2) begin
         check_int("rst_rx_b0", int'(rx_q[0]), 8'h3C);
         check_int("rst_rx_b1", int'(rx_q[1]), 8'h31);
      end
      #2;
      rst_n = 1'b0;
      base = nf;
      m_ovr = 1'b0;
      rx_active = 1'b0;
      flush_queues();
      #1;
      check("rst_async_tx", tx, 1'b1);
      check("rst_async_busy", tx_busy, 1'b0);
      idle(3);
      rst_n = 1'b1;
      idle(FL);
      check("rst_no_resume", tx_busy, 1'b0);
      for (int i = 0; i < 7; i++) send_gated(msg[i]);
      idle(FL + 10);
      check_int("msg_rx_count", rx_q.size(), 7);
      for (int i = 0; i < rx_q.size() && i < 7; i++)
         check_int("msg_rx_byte", int'(rx_q[i]), int'(msg[i]));
      check("msg_overrun", tx_overrun, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
